// File: rtl/vlc_pkg.sv
// Shared widths and state encoding for the VLC bit packer and related
// bitstream writers.
package vlc_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned ACC_W   = 64;
   localparam int unsigned LEN_MAX = 32;
   localparam int unsigned FILL_W  = 6;
   localparam int unsigned BYTES_W = 3;
   localparam int unsigned NFILL_W = 7;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;

endpackage : vlc_pkg

// File: rtl/vlc_len_mask.sv
// Purpose : combinational codeword-length to low-bit mask.
// Ports   : len_i    - length in bits (0..32; anything >=32 yields all ones)
//           mask_c_o - mask with the len_i least-significant bits set
module vlc_len_mask
   import vlc_pkg::*;
(
   input  logic [WORD_W-1:0] len_i,
   output logic [WORD_W-1:0] mask_c_o
);

   logic [WORD_W:0] one_sh;

   // One extra bit so that a shift by 31 minus one never underflows.
   always_comb begin
      one_sh   = '0;
      mask_c_o = '1;
      if (len_i < WORD_W'(LEN_MAX)) begin
         one_sh   = (WORD_W+1)'(1) << len_i[4:0];
         mask_c_o = WORD_W'(one_sh - (WORD_W+1)'(1));
      end
   end

endmodule : vlc_len_mask

// File: rtl/vlc_bit_packer.sv
// Purpose : packs (value, length) codewords MSB-first into 32-bit words; on
//           flush pads the residual to a byte boundary, emits it and reports
//           the segment size in bytes.
// Ports   : clk, reset_n         - clock, async active-low reset
//           in_valid/in_code/in_len - codeword (right-justified) and length
//           flush                - end of segment
//           out_valid/out_word/out_bytes - packed word, first bit at bit 31
//           busy                 - high in the FLUSH cycle
//           done/seg_bytes       - flush-complete pulse with segment bytes
//           err                  - sticky protocol error
module vlc_bit_packer
   import vlc_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   input  logic [WORD_W-1:0]   in_code,
   input  logic [WORD_W-1:0]   in_len,
   input  logic                flush,
   output logic                out_valid,
   output logic [WORD_W-1:0]   out_word,
   output logic [BYTES_W-1:0]  out_bytes,
   output logic                busy,
   output logic                done,
   output logic [WORD_W-1:0]   seg_bytes,
   output logic                err
);

   state_e               state_q, state_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic [WORD_W-1:0]    seg_bits_q, seg_bits_d;
   logic                 out_valid_q, out_valid_d;
   logic [WORD_W-1:0]    out_word_q, out_word_d;
   logic [BYTES_W-1:0]   out_bytes_q, out_bytes_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [WORD_W-1:0]    seg_bytes_q, seg_bytes_d;
   logic                 err_q, err_d;

   logic [WORD_W-1:0]    code_mask;
   logic [WORD_W-1:0]    tail_mask;
   logic [WORD_W-1:0]    tail_len;
   logic                 len_legal;
   logic                 len_over;
   logic [NFILL_W-1:0]   len7;
   logic [NFILL_W-1:0]   new_fill;
   logic [ACC_W-1:0]     placed;
   logic [ACC_W-1:0]     acc_app;
   logic [WORD_W-1:0]    seg_ceil;
   logic [FILL_W-1:0]    fill_round;

   // Keeps only the codeword bits below in_len.
   vlc_len_mask u_code_mask (
      .len_i    (in_len),
      .mask_c_o (code_mask)
   );

   // Low bits of the residual word that lie beyond fill.
   assign tail_len = WORD_W'(LEN_MAX) - WORD_W'(fill_q);

   vlc_len_mask u_tail_mask (
      .len_i    (tail_len),
      .mask_c_o (tail_mask)
   );

   // Datapath helpers; only meaningful when the codeword is legal.
   always_comb begin
      len_over   = in_len > WORD_W'(LEN_MAX);
      len_legal  = (in_len != '0) && !len_over;
      len7       = NFILL_W'(in_len[5:0]);
      new_fill   = NFILL_W'(fill_q) + len7;
      // Top code bit lands at 63-fill, so shift left by 64-fill-len.
      placed     = {{(ACC_W-WORD_W){1'b0}}, in_code & code_mask}
                   << (NFILL_W'(ACC_W) - new_fill);
      acc_app    = acc_q | placed;
      seg_ceil   = (seg_bits_q >> 3) + WORD_W'(seg_bits_q[2:0] != 3'd0);
      fill_round = fill_q + FILL_W'(7);
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      fill_d      = fill_q;
      seg_bits_d  = seg_bits_q;
      out_valid_d = 1'b0;
      out_word_d  = '0;
      out_bytes_d = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      seg_bytes_d = '0;
      err_d       = err_q;

      if (in_valid && len_over) begin
         err_d = 1'b1;
      end

      case (state_q)
         RUN: begin
            if (in_valid && len_legal) begin
               seg_bits_d = seg_bits_q + in_len;
               if (new_fill >= NFILL_W'(WORD_W)) begin
                  out_valid_d = 1'b1;
                  out_word_d  = acc_app[ACC_W-1:WORD_W];
                  out_bytes_d = BYTES_W'(4);
                  acc_d       = {acc_app[WORD_W-1:0], {WORD_W{1'b0}}};
                  fill_d      = FILL_W'(new_fill - NFILL_W'(WORD_W));
               end else begin
                  acc_d  = acc_app;
                  fill_d = FILL_W'(new_fill);
               end
            end
            if (flush) begin
               state_d = FLUSH;
               busy_d  = 1'b1;
            end
         end

         FLUSH: begin
            // Codewords arriving while flushing are dropped.
            if (in_valid && (in_len != '0)) begin
               err_d = 1'b1;
            end
            if (fill_q != '0) begin
               out_valid_d = 1'b1;
               out_word_d  = acc_q[ACC_W-1:WORD_W] & ~tail_mask;
               out_bytes_d = BYTES_W'(fill_round >> 3);
            end
            done_d      = 1'b1;
            seg_bytes_d = seg_ceil;
            acc_d       = '0;
            fill_d      = '0;
            seg_bits_d  = '0;
            state_d     = RUN;
         end

         default: state_d = RUN;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RUN;
         acc_q       <= '0;
         fill_q      <= '0;
         seg_bits_q  <= '0;
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
         out_bytes_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         seg_bytes_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         fill_q      <= fill_d;
         seg_bits_q  <= seg_bits_d;
         out_valid_q <= out_valid_d;
         out_word_q  <= out_word_d;
         out_bytes_q <= out_bytes_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         seg_bytes_q <= seg_bytes_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_word  = out_word_q;
   assign out_bytes = out_bytes_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign seg_bytes = seg_bytes_q;
   assign err       = err_q;

endmodule : vlc_bit_packer
